// File: rtl/noc_pkg.sv
// noc_pkg: shared types and helpers for the router input/output ports.
//   - flit geometry and field bit positions
//   - flit_type_t, port_t enums
//   - xy_route(): dimension-ordered (X first, then Y) route computation
package noc_pkg;

    localparam int FLIT_W    = 16;
    localparam int NUM_PORTS = 5;
    localparam int COORD_W   = 3;

    localparam int TYPE_HI = 15;
    localparam int TYPE_LO = 14;
    localparam int DX_HI   = 13;
    localparam int DX_LO   = 11;
    localparam int DY_HI   = 10;
    localparam int DY_LO   = 8;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_t;

    // Value doubles as the bit index in the one-hot request vector.
    typedef enum logic [2:0] {
        P_L = 3'd0,
        P_N = 3'd1,
        P_E = 3'd2,
        P_S = 3'd3,
        P_W = 3'd4
    } port_t;

    // X is resolved completely before Y, which keeps XY routing deadlock-free.
    function automatic port_t xy_route(input logic [COORD_W-1:0] dest_x,
                                       input logic [COORD_W-1:0] dest_y,
                                       input logic [COORD_W-1:0] my_x,
                                       input logic [COORD_W-1:0] my_y);
        if (dest_x > my_x)      return P_E;
        else if (dest_x < my_x) return P_W;
        else if (dest_y > my_y) return P_N;
        else if (dest_y < my_y) return P_S;
        else                    return P_L;
    endfunction

endpackage

// File: rtl/noc_input_port_if.sv
// noc_input_port_if: link and allocator signals of one router input port.
//   data_i/valid_i  : flit stream from the upstream router
//   credit_o        : one-cycle credit return to upstream
//   req_o/grant_i   : one-hot output-port request and its grant
//   data_o/empty_o  : head-of-buffer flit and buffer-empty flag
//   err_o           : sticky protocol error (only with NOC_INPUT_PORT_ERR_EN)
// Modports: slave = the input port, master = the driving environment.
interface noc_input_port_if
    import noc_pkg::*;
#(
    parameter int WIDTH = FLIT_W
);
    logic [WIDTH-1:0]     data_i;
    logic                 valid_i;
    logic                 credit_o;
    logic [NUM_PORTS-1:0] req_o;
    logic                 grant_i;
    logic [WIDTH-1:0]     data_o;
    logic                 empty_o;
`ifdef NOC_INPUT_PORT_ERR_EN
    logic                 err_o;
`endif

    modport slave (
        input  data_i, valid_i, grant_i,
`ifdef NOC_INPUT_PORT_ERR_EN
        output err_o,
`endif
        output credit_o, req_o, data_o, empty_o
    );

    modport master (
        output data_i, valid_i, grant_i,
`ifdef NOC_INPUT_PORT_ERR_EN
        input  err_o,
`endif
        input  credit_o, req_o, data_o, empty_o
    );

endinterface

// File: rtl/noc_fifo.sv
// noc_fifo: synchronous FIFO with registered occupancy count.
//   push_i/data_i : write request, ignored while full (even with a pop)
//   pop_i         : read request, ignored while empty
//   data_o        : head entry, forced to zero while empty
//   count_o/full_o/empty_o : occupancy
// Reset is synchronous, active-high.
module noc_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 5,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = ptr_inc(wr_q);
        end
        if (do_pop) begin
            rd_d = ptr_inc(rd_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: data_o is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/noc_input_port.sv
// noc_input_port: receiving end of a credit-based router-to-router link.
// Buffers incoming flits, routes each packet by XY on its head flit, holds the
// one-hot request to the switch allocator until the tail leaves, and returns
// one credit per flit removed from the buffer.
//   clk, rst : clock, synchronous active-high reset
//   port_if  : noc_input_port_if.slave (link, allocator and status signals)
// Optional macro NOC_INPUT_PORT_ERR_EN adds sticky err_o, set by a refused
// push (credit violation) or by discarding an orphan BODY/TAIL flit.
//
// state  | meaning
// IDLE   | no packet open; route a HEAD/SINGLE head flit or discard an orphan
// ACTIVE | packet open; request route_q until the TAIL/SINGLE flit is granted
module noc_input_port
    import noc_pkg::*;
#(
    parameter int DEPTH   = 5,
    parameter int WIDTH   = 16,
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0
) (
    input  logic              clk,
    input  logic              rst,
    noc_input_port_if.slave   port_if
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] route_q, route_d;
    logic                 credit_q, credit_d;
    logic                 pop;
    logic [WIDTH-1:0]     fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full, fifo_empty;
    flit_type_t           head_type;

    noc_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (port_if.valid_i),
        .data_i  (port_if.data_i),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_type = flit_type_t'(fifo_head[TYPE_HI:TYPE_LO]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            route_q  <= '0;
            credit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            route_q  <= route_d;
            credit_q <= credit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_type == HEAD || head_type == SINGLE) begin
                        route_d = NUM_PORTS'(1) << xy_route(fifo_head[DX_HI:DX_LO],
                                                            fifo_head[DY_HI:DY_LO],
                                                            COORD_W'(X_COORD),
                                                            COORD_W'(Y_COORD));
                        state_d = ACTIVE;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // route_q is one-hot here, so req_o != 0 reduces to !fifo_empty.
                if (!fifo_empty && port_if.grant_i) begin
                    pop = 1'b1;
                    if (head_type == TAIL || head_type == SINGLE) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        credit_d = pop;
    end

    always_comb begin
        port_if.req_o = '0;
        if (state_q == ACTIVE && !fifo_empty) begin
            port_if.req_o = route_q;
        end
    end

    assign port_if.credit_o = credit_q;
    assign port_if.data_o   = fifo_head;
    assign port_if.empty_o  = fifo_empty;

`ifdef NOC_INPUT_PORT_ERR_EN
    logic err_q, err_d;

    // An orphan discard is exactly a pop taken in IDLE.
    always_comb begin
        err_d = err_q
              | (port_if.valid_i && fifo_full)
              | (pop && state_q == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign port_if.err_o = err_q;
`endif

    // FIFO occupancy flags must always agree with its count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_count <= CNT_W'(DEPTH)
                    && fifo_full == (fifo_count == CNT_W'(DEPTH))
                    && fifo_empty == (fifo_count == '0));
        end
    end

endmodule

// File: tb/tb_noc_input_port.sv
module tb_noc_input_port;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    noc_input_port_if #(.WIDTH(16)) bus ();

    noc_input_port #(
        .DEPTH   (5),
        .WIDTH   (16),
        .X_COORD (0),
        .Y_COORD (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .port_if (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.grant_i = 1'b0;
        bus.data_i  = '0;
        tick();
        tick();
        n_vec++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.empty_o); end
        n_vec++; if (bus.req_o !== 5'b0) begin n_err++; $display("FAIL reset_req: got %b want 00000", bus.req_o); end
        n_vec++; if (bus.credit_o !== 1'b0) begin n_err++; $display("FAIL reset_credit: got %b want 0", bus.credit_o); end
        n_vec++; if (bus.data_o !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h want 0000", bus.data_o); end
`ifdef NOC_INPUT_PORT_ERR_EN
        n_vec++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
`endif
        rst = 1'b0;
    endtask

    // SINGLE to (1,0): E request two cycles after arrival; a grant while
    // still in IDLE must not pop.
    task automatic test_single();
        bus.valid_i = 1'b1;
        bus.data_i  = 16'hC800;
        tick();
        bus.valid_i = 1'b0;
        n_vec++; if (bus.req_o !== 5'b0) begin n_err++; $display("FAIL single_req_t1: got %b want 00000", bus.req_o); end
        n_vec++; if (bus.data_o !== 16'hC800) begin n_err++; $display("FAIL single_head: got %h want c800", bus.data_o); end
        bus.grant_i = 1'b1;
        tick();
        n_vec++; if (bus.credit_o !== 1'b0) begin n_err++; $display("FAIL single_idle_grant: credit got %b want 0", bus.credit_o); end
        n_vec++; if (bus.req_o !== 5'b00100) begin n_err++; $display("FAIL single_req_t2: got %b want 00100", bus.req_o); end
        n_vec++; if (bus.data_o !== 16'hC800) begin n_err++; $display("FAIL single_data: got %h want c800", bus.data_o); end
        tick();
        bus.grant_i = 1'b0;
        n_vec++; if (bus.credit_o !== 1'b1) begin n_err++; $display("FAIL single_credit: got %b want 1", bus.credit_o); end
        n_vec++; if (bus.req_o !== 5'b0) begin n_err++; $display("FAIL single_req_after: got %b want 00000", bus.req_o); end
        n_vec++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b want 1", bus.empty_o); end
        tick();
        n_vec++; if (bus.credit_o !== 1'b0) begin n_err++; $display("FAIL single_credit_once: got %b want 0", bus.credit_o); end
    endtask

    // HEAD/BODY/BODY/TAIL to (0,0), streamed back-to-back with grant held.
    task automatic test_packet();
        logic [15:0] pkt [4] = '{16'h4000, 16'h0001, 16'h0002, 16'h8003};
        logic [4:0]  exp_req;
        logic        exp_cr;
        bus.grant_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.valid_i = (i < 4);
            bus.data_i  = (i < 4) ? pkt[i] : 16'h0;
            tick();
            exp_req = (i >= 1 && i <= 4) ? 5'b00001 : 5'b00000;
            exp_cr  = (i >= 2 && i <= 5);
            n_vec++; if (bus.req_o !== exp_req) begin n_err++; $display("FAIL packet_req[%0d]: got %b want %b", i, bus.req_o, exp_req); end
            n_vec++; if (bus.credit_o !== exp_cr) begin n_err++; $display("FAIL packet_credit[%0d]: got %b want %b", i, bus.credit_o, exp_cr); end
            if (i >= 1 && i <= 4) begin
                n_vec++; if (bus.data_o !== pkt[i-1]) begin n_err++; $display("FAIL packet_data[%0d]: got %h want %h", i, bus.data_o, pkt[i-1]); end
            end
        end
        bus.grant_i = 1'b0;
        bus.valid_i = 1'b0;
    endtask

    // Six flits with no grant: the sixth is refused and never comes out.
    task automatic test_overflow();
        logic [15:0] ov [6] = '{16'h4000, 16'h0011, 16'h0012, 16'h0013, 16'h8014, 16'h0015};
        int k;
        int cr;
        bus.grant_i = 1'b0;
`ifdef NOC_INPUT_PORT_ERR_EN
        n_vec++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL ovf_err_pre: got %b want 0", bus.err_o); end
`endif
        for (int i = 0; i < 6; i++) begin
            bus.valid_i = 1'b1;
            bus.data_i  = ov[i];
            tick();
            n_vec++; if (bus.credit_o !== 1'b0) begin n_err++; $display("FAIL ovf_credit[%0d]: got %b want 0", i, bus.credit_o); end
`ifdef NOC_INPUT_PORT_ERR_EN
            if (i == 4) begin
                n_vec++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL ovf_err_full: got %b want 0", bus.err_o); end
            end
`endif
        end
        bus.valid_i = 1'b0;
        n_vec++; if (bus.req_o !== 5'b00001) begin n_err++; $display("FAIL ovf_req: got %b want 00001", bus.req_o); end
`ifdef NOC_INPUT_PORT_ERR_EN
        n_vec++; if (bus.err_o !== 1'b1) begin n_err++; $display("FAIL ovf_err: got %b want 1", bus.err_o); end
`endif
        bus.grant_i = 1'b1;
        k  = 0;
        cr = 0;
        for (int i = 0; i < 9; i++) begin
            if (bus.req_o !== 5'b0) begin
                n_vec++;
                if (k >= 5) begin n_err++; $display("FAIL ovf_extra_flit: got %h want none", bus.data_o); end
                else if (bus.data_o !== ov[k]) begin n_err++; $display("FAIL ovf_data[%0d]: got %h want %h", k, bus.data_o, ov[k]); end
                k++;
            end
            if (bus.credit_o === 1'b1) cr++;
            tick();
        end
        bus.grant_i = 1'b0;
        n_vec++; if (k != 5) begin n_err++; $display("FAIL ovf_flits_out: got %0d want 5", k); end
        n_vec++; if (cr != 5) begin n_err++; $display("FAIL ovf_credits: got %0d want 5", cr); end
        n_vec++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL ovf_empty: got %b want 1", bus.empty_o); end
    endtask

    task automatic test_orphan();
        bus.valid_i = 1'b1;
        bus.data_i  = 16'h0123;
        tick();
        bus.valid_i = 1'b0;
        n_vec++; if (bus.req_o !== 5'b0) begin n_err++; $display("FAIL orphan_req_t1: got %b want 00000", bus.req_o); end
        n_vec++; if (bus.credit_o !== 1'b0) begin n_err++; $display("FAIL orphan_credit_t1: got %b want 0", bus.credit_o); end
        tick();
        n_vec++; if (bus.credit_o !== 1'b1) begin n_err++; $display("FAIL orphan_credit: got %b want 1", bus.credit_o); end
        n_vec++; if (bus.req_o !== 5'b0) begin n_err++; $display("FAIL orphan_req_t2: got %b want 00000", bus.req_o); end
        n_vec++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL orphan_empty: got %b want 1", bus.empty_o); end
        tick();
        n_vec++; if (bus.credit_o !== 1'b0) begin n_err++; $display("FAIL orphan_credit_once: got %b want 0", bus.credit_o); end
    endtask

    // Packet to (0,2) then SINGLE to (3,0): N for the whole first packet,
    // a gap cycle for re-routing, then E.
    task automatic test_back_to_back();
        logic [15:0] fl [4]  = '{16'h4200, 16'h0021, 16'h8022, 16'hD800};
        logic [4:0]  er [7]  = '{5'b00000, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00100, 5'b00000};
        logic [15:0] ed [7]  = '{16'h0, 16'h4200, 16'h0021, 16'h8022, 16'h0, 16'hD800, 16'h0};
        bus.grant_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.valid_i = (i < 4);
            bus.data_i  = (i < 4) ? fl[i] : 16'h0;
            tick();
            n_vec++; if (bus.req_o !== er[i]) begin n_err++; $display("FAIL b2b_req[%0d]: got %b want %b", i, bus.req_o, er[i]); end
            if (er[i] != 5'b0) begin
                n_vec++; if (bus.data_o !== ed[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.data_o, ed[i]); end
            end
        end
        bus.grant_i = 1'b0;
        bus.valid_i = 1'b0;
        n_vec++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", bus.empty_o); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] fl [3] = '{16'h4000, 16'h0001, 16'h0002};
        bus.grant_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.valid_i = 1'b1;
            bus.data_i  = fl[i];
            tick();
        end
        bus.valid_i = 1'b0;
        n_vec++; if (bus.req_o !== 5'b00001) begin n_err++; $display("FAIL mid_req_pre: got %b want 00001", bus.req_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL mid_empty: got %b want 1", bus.empty_o); end
        n_vec++; if (bus.req_o !== 5'b0) begin n_err++; $display("FAIL mid_req: got %b want 00000", bus.req_o); end
        n_vec++; if (bus.credit_o !== 1'b0) begin n_err++; $display("FAIL mid_credit: got %b want 0", bus.credit_o); end
        n_vec++; if (bus.data_o !== 16'h0) begin n_err++; $display("FAIL mid_data: got %h want 0000", bus.data_o); end
`ifdef NOC_INPUT_PORT_ERR_EN
        n_vec++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL mid_err: got %b want 0", bus.err_o); end
`endif
        bus.valid_i = 1'b1;
        bus.data_i  = 16'hC100;
        tick();
        bus.valid_i = 1'b0;
        n_vec++; if (bus.req_o !== 5'b0) begin n_err++; $display("FAIL mid_new_req_t1: got %b want 00000", bus.req_o); end
        tick();
        n_vec++; if (bus.req_o !== 5'b00010) begin n_err++; $display("FAIL mid_new_req: got %b want 00010", bus.req_o); end
        n_vec++; if (bus.data_o !== 16'hC100) begin n_err++; $display("FAIL mid_new_data: got %h want c100", bus.data_o); end
        bus.grant_i = 1'b1;
        tick();
        bus.grant_i = 1'b0;
        n_vec++; if (bus.credit_o !== 1'b1) begin n_err++; $display("FAIL mid_new_credit: got %b want 1", bus.credit_o); end
        n_vec++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL mid_new_empty: got %b want 1", bus.empty_o); end
    endtask

    initial begin
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.grant_i = 1'b0;
        bus.data_i  = '0;
        test_reset();
        test_single();
        test_packet();
        test_overflow();
        test_orphan();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/noc_input_port.md
Name: noc_input_port

Overview:
- Receiving end of the router-to-router credit link: accepts flits from the upstream router's output port, buffers them, computes the XY route from each head flit, and holds the packet's request to the switch allocator until the tail flit leaves.
- Returns one credit pulse upstream per flit drained. The upstream output port starts with DEPTH credits, so a correctly behaving sender never overflows this buffer.

Parameters:
- DEPTH, 5, buffer entries; must equal the upstream initial credit count.
- WIDTH, 16, flit width in bits.
- X_COORD, 0, this router's X coordinate, 3 bits.
- Y_COORD, 0, this router's Y coordinate, 3 bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high.
- data_i  in  WIDTH  flit from upstream; qualified by valid_i.
- valid_i  in  1  upstream send strobe; one flit per cycle.
- credit_o  out  1  one-cycle credit-return pulse to upstream.
- req_o  out  5  one-hot output-port request to the switch allocator (bit 0 L, 1 N, 2 E, 3 S, 4 W).
- grant_i  in  1  allocator grant for the current req_o; consumes the head flit this cycle.
- data_o  out  WIDTH  head-of-buffer flit; valid whenever req_o != 0.
- empty_o  out  1  buffer empty.

Behaviour:
- Flit format:
  - [15:14] type: 00 BODY, 01 HEAD, 10 TAIL, 11 SINGLE.
  - HEAD/SINGLE [13:11] dest_x, [10:8] dest_y.
- Buffer: synchronous FIFO with a registered count. Push when valid_i && count != DEPTH.
  - A push while full is refused even if a pop happens the same cycle; the flit is dropped.
  - A flit pushed in cycle t is at the head at t+1.
  - Simultaneous push and pop when not full: count is unchanged.
- Route (combinational on head flit), in priority order:
  - dest_x > X_COORD -> E
  - dest_x < X_COORD -> W
  - dest_y > Y_COORD -> N
  - dest_y < Y_COORD -> S
  - otherwise -> L
- FSM states IDLE and ACTIVE. route_q is a 5-bit register.
  - IDLE with buffer non-empty:
    - Head type HEAD or SINGLE: latch route into route_q and go to ACTIVE next cycle. req_o = 0 in IDLE.
    - Head type BODY or TAIL (orphan): pop and discard it, return its credit, stay in IDLE.
  - ACTIVE: req_o = route_q when !empty, else 0.
    - grant_i while req_o != 0: pop the head flit.
    - If the popped flit is TAIL or SINGLE, go to IDLE.
    - grant_i while req_o == 0 is ignored.
- Credit: credit_o is registered and asserts the cycle after any pop, including orphan discards. Exactly one pulse per pop.
- Latency: flit arrives at t -> earliest req_o at t+2 for a head flit (t+1 at buffer head, t+2 in ACTIVE). Body flits in ACTIVE: req_o at t+1.
- A HEAD flit arriving while ACTIVE is buffered; it is routed only after the current tail leaves.
- Reset, including mid-packet:
  - Buffer emptied; FSM -> IDLE.
  - route_q = 0, credit_o = 0, req_o = 0, empty_o = 1, data_o = 0.
  - The upstream port shares rst, so its credits are restored to DEPTH at the same time.

Optional Feature:
- Macro: NOC_INPUT_PORT_ERR_EN.
- Defined:
  - Adds output port err_o (1 bit), sticky, cleared only by rst.
  - err_o sets the cycle after either a refused push (credit protocol violation) or an orphan-flit discard.
- Undefined: port absent; both conditions are silently dropped as described above.

Decomposition:
- noc_pkg holds:
  - FLIT_W = 16, NUM_PORTS = 5, COORD_W = 3.
  - flit_type_t enum (BODY, HEAD, TAIL, SINGLE).
  - port_t enum (P_L, P_N, P_E, P_S, P_W).
  - Field bit-position constants.
  - xy_route function returning port_t.
- One sub-module: noc_fifo, a parameterised width/depth synchronous FIFO with count, full and empty. It is reusable by the output port.

Test Plan:
- Reset, then SINGLE flit 16'hC800 (dest 1,0) at router (0,0) -> req_o = 5'b00100 (E) two cycles later; grant_i -> data_o = 16'hC800 popped, credit_o pulses next cycle, FSM back to IDLE.
- 4-flit packet HEAD/BODY/BODY/TAIL to dest (0,0) at router (0,0), grant held high -> req_o = 5'b00001 for 4 consecutive cycles, 4 credit pulses, then req_o = 0.
- 5 flits sent with grant_i low -> buffer full; 6th valid_i -> flit dropped, count stays 5, no extra credit; with NOC_INPUT_PORT_ERR_EN defined, err_o = 1.
- Orphan BODY flit 16'h0123 while IDLE -> discarded, credit_o pulse, req_o stays 0.
- Packet to (0,2) followed back-to-back by a packet to (3,0) at router (0,0) -> req_o = N for the first packet; after its TAIL pops, req_o = E; no interleaving.
- rst asserted mid-packet with 3 flits buffered -> next cycle empty_o = 1, req_o = 0, credit_o = 0; a new HEAD flit is then routed normally.
